// File: rtl/nand_grid_pkg.sv
// nand_grid_pkg: definitions shared by the NAND grid pipeline.
//   mode_t     : operating mode. Functional, LFSR stress and static hold are
//                defined; the reserved encoding behaves like functional.
//   LFSR_TAPS  : tap mask for the stimulus LFSR (taps 16,14,13,11).
//   MISR_TAPS  : tap mask for the output signature register (same polynomial).
//   shift_fb() : one left shift of a 16-bit Fibonacci register, with the XOR
//                of the tapped bits fed in at bit 0.
package nand_grid_pkg;

    typedef enum logic [1:0] {
        MODE_FUNC   = 2'd0,
        MODE_STRESS = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    // Taps 16,14,13,11 are bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] MISR_TAPS = 16'hB400;

    function automatic logic [15:0] shift_fb(input logic [15:0] v,
                                             input logic [15:0] taps);
        return {v[14:0], ^(v & taps)};
    endfunction

endpackage

// File: rtl/nand_grid_comb.sv
// nand_grid_comb: the two-layer NAND2 network, purely combinational.
//   x   [2*NPAIR-1:0] in  : primary inputs, feeding layer 1.
//   m   [NPAIR-1:0]   out : layer-1 results, m[i] = NAND(x[2i], x[2i+1]).
//   m_q [NPAIR-1:0]   in  : registered layer-1 results, feeding layer 2.
//   y   [NPAIR-1:0]   out : layer-2 results.
// The two layers are exposed separately so the parent can place a
// register stage between them.
module nand_grid_comb
    import nand_grid_pkg::*;
#(
    parameter int NPAIR = 4
) (
    input  logic [2*NPAIR-1:0] x,
    output logic [NPAIR-1:0]   m,
    input  logic [NPAIR-1:0]   m_q,
    output logic [NPAIR-1:0]   y
);

    localparam int HALF = NPAIR / 2;

    for (genvar i = 0; i < NPAIR; i++) begin : g_layer1
        assign m[i] = ~(x[2*i] & x[2*i+1]);
    end

    // Lower half combines adjacent pairs, upper half combines pairs that
    // are HALF apart, so every output mixes two distinct first-layer gates.
    for (genvar j = 0; j < HALF; j++) begin : g_layer2
        assign y[j]        = ~(m_q[2*j] & m_q[2*j+1]);
        assign y[HALF + j] = ~(m_q[j]   & m_q[j+HALF]);
    end

endmodule

// File: rtl/nand_grid_pipe.sv
// nand_grid_pipe: two-stage pipelined NAND grid with LFSR stress source,
// static hold source, output MISR and saturating handshake counter.
//   clk        in  : sole clock, rising edge.
//   rst        in  : synchronous active-high reset.
//   mode [1:0] in  : 0 functional, 1 LFSR stress, 2 static hold, 3 as 0.
//   in_valid   in  : in_data valid (functional mode only).
//   in_ready   out : in_data accepted this cycle.
//   in_data    in  : primary inputs, 2*NPAIR bits.
//   out_valid  out : out_data valid.
//   out_ready  in  : consumer takes out_data.
//   out_data   out : primary outputs, NPAIR bits.
//   sig  [15:0] out: MISR signature of every accepted output.
//   cnt  [15:0] out: output handshake count, saturating at 16'hFFFF.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds data stable while valid && !ready, and ready
// may depend combinationally on the far side's ready.
// NPAIR must be even in 2..16 and SEED must be nonzero.
module nand_grid_pipe
    import nand_grid_pkg::*;
#(
    parameter int          NPAIR = 4,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*NPAIR-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NPAIR-1:0]   out_data,
    output logic [15:0]        sig,
    output logic [15:0]        cnt
);

    localparam int XW = 2 * NPAIR;

    mode_t            md;
    logic             advance;
    logic             handshake;
    logic [XW-1:0]    x;
    logic             x_valid;
    logic [XW-1:0]    lfsr_x;
    logic [NPAIR-1:0] m;
    logic [NPAIR-1:0] y;
    logic [15:0]      out_ext;

    logic             s1_valid;
    logic [NPAIR-1:0] s1_m;
    logic [XW-1:0]    cap;
    logic [15:0]      lfsr;

    assign md = mode_t'(mode);

    // Both stages move together; a stalled output freezes the whole pipe,
    // so bubbles keep their slot instead of being squeezed out.
    assign advance   = !out_valid || out_ready;
    assign handshake = out_valid && out_ready;

    // LFSR drives the low inputs; wider grids see zeros above bit 15.
    if (XW > 16) begin : g_lfsr_wide
        assign lfsr_x = {{(XW-16){1'b0}}, lfsr};
    end else if (XW == 16) begin : g_lfsr_eq
        assign lfsr_x = lfsr;
    end else begin : g_lfsr_narrow
        assign lfsr_x = lfsr[XW-1:0];
    end

    // Input source selection.
    always_comb begin
        x       = in_data;
        x_valid = in_valid;
        unique case (md)
            MODE_STRESS: begin
                x       = lfsr_x;
                x_valid = 1'b1;
            end
            MODE_HOLD: begin
                x       = cap;
                x_valid = 1'b1;
            end
            default: begin
                x       = in_data;
                x_valid = in_valid;
            end
        endcase
    end

    assign in_ready = !rst && advance && (md == MODE_FUNC || md == MODE_RSVD);

    always_comb begin
        out_ext              = '0;
        out_ext[NPAIR-1:0]   = out_data;
    end

    nand_grid_comb #(
        .NPAIR (NPAIR)
    ) u_comb (
        .x   (x),
        .m   (m),
        .m_q (s1_m),
        .y   (y)
    );

    // Pipeline stages, input capture and LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_m      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cap       <= '0;
            lfsr      <= SEED;
        end else if (advance) begin
            s1_valid  <= x_valid;
            s1_m      <= m;
            out_valid <= s1_valid;
            out_data  <= y;
            // Capture happens on every load so hold mode replays whatever
            // the grid saw last, whichever source that was.
            cap       <= x;
            if (md == MODE_STRESS) begin
                lfsr <= shift_fb(lfsr, LFSR_TAPS);
            end
        end
    end

    // Signature and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= '0;
            cnt <= '0;
        end else if (handshake) begin
            sig <= shift_fb(sig, MISR_TAPS) ^ out_ext;
            if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nand_grid_pipe.sv
// tb_nand_grid_pipe: randomized scoreboard bench for nand_grid_pipe with
// NPAIR = 4. The driver pushes the grid result of every accepted input into
// exp_q; the monitor pops on every output handshake and also tracks the
// expected signature and counter.
module tb_nand_grid_pipe;

    localparam int          NPAIR = 4;
    localparam int          W     = 2 * NPAIR;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [NPAIR-1:0] out_data;
    logic [15:0]      sig;
    logic [15:0]      cnt;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        rst       = 1'b1;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
    end

    nand_grid_pipe #(
        .NPAIR (NPAIR),
        .SEED  (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sig       (sig),
        .cnt       (cnt)
    );

    // reference model state
    logic [NPAIR-1:0] exp_q[$];
    logic [15:0]      lfsr_m;
    logic [15:0]      sig_m;
    logic [15:0]      cnt_m;
    logic [W-1:0]     cap_m;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Grid output straight from the gate equations.
    function automatic logic [NPAIR-1:0] ref_grid(input logic [W-1:0] xv);
        logic [NPAIR-1:0] mm;
        logic [NPAIR-1:0] yy;
        for (int i = 0; i < NPAIR; i++)
            mm[i] = !(xv[2*i] && xv[2*i+1]);
        for (int j = 0; j < NPAIR/2; j++) begin
            yy[j]           = !(mm[2*j] && mm[2*j+1]);
            yy[NPAIR/2 + j] = !(mm[j] && mm[j+NPAIR/2]);
        end
        return yy;
    endfunction

    function automatic logic [15:0] step16(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            check("sig", 32'(sig), 32'(sig_m));
            check("cnt", 32'(cnt), 32'(cnt_m));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h expected none", out_data);
                end else begin
                    logic [NPAIR-1:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e));
                    sig_m = step16(sig_m) ^ {{(16-NPAIR){1'b0}}, e};
                    if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
                end
            end
        end
    end

    // driver: one clock cycle of stimulus, then model update at negedge.
    // Stress/hold cycles are always driven with out_ready = 1.
    task automatic cycle(input logic r, input logic [1:0] md, input logic v,
                         input logic [W-1:0] d, input logic ordy,
                         output logic acc);
        logic [1:0] eff;
        logic       adv;
        @(posedge clk);
        #1;
        rst       = r;
        mode      = md;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        acc = 1'b0;
        if (r) begin
            check("in_ready_rst", 32'(in_ready), 32'd0);
            exp_q.delete();
            lfsr_m = SEED;
            cap_m  = '0;
            sig_m  = '0;
            cnt_m  = '0;
        end else begin
            eff = (md == 2'd3) ? 2'd0 : md;
            if (eff == 2'd0) begin
                adv = in_ready;
                if (ordy) check("in_ready_func", 32'(in_ready), 32'd1);
            end else begin
                adv = 1'b1;
                check("in_ready_gen", 32'(in_ready), 32'd0);
            end
            if (adv) begin
                case (eff)
                    2'd1: begin
                        exp_q.push_back(ref_grid(lfsr_m[W-1:0]));
                        cap_m  = lfsr_m[W-1:0];
                        lfsr_m = step16(lfsr_m);
                        acc    = 1'b1;
                    end
                    2'd2: begin
                        exp_q.push_back(ref_grid(cap_m));
                        acc = 1'b1;
                    end
                    default: begin
                        if (v) begin
                            exp_q.push_back(ref_grid(d));
                            acc = 1'b1;
                        end
                        cap_m = d;
                    end
                endcase
            end
        end
    endtask

    task automatic do_reset();
        logic a;
        cycle(1'b1, 2'd0, 1'b0, '0, 1'b1, a);
        cycle(1'b1, 2'd0, 1'b0, '0, 1'b1, a);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
    endtask

    task automatic drain();
        logic a;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle(1'b0, 2'd0, 1'b0, '0, 1'b1, a);
            n++;
        end
        cycle(1'b0, 2'd0, 1'b0, '0, 1'b1, a);
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] rnd_data();
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    initial begin
        logic       a;
        logic [W-1:0] d030[3];
        logic [W-1:0] d031[6];
        logic [1:0] md;
        logic       ordy;
        int         idx;
        int         cyc;

        d030[0] = 8'hFF;
        d030[1] = 8'h00;
        d030[2] = 8'h03;

        // reset state
        do_reset();

        // three back-to-back functional items
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b1, d030[i], 1'b1, a);
        drain();
        check("cnt_after_3", 32'(cnt), 32'd3);

        // six items with a five-cycle output stall mid-stream
        do_reset();
        for (int i = 0; i < 6; i++) d031[i] = rnd_data();
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 40) begin
            ordy = !(cyc >= 3 && cyc < 8);
            cycle(1'b0, 2'd0, 1'b1, d031[idx], ordy, a);
            if (!ordy && cyc >= 4) check("in_ready_stall", 32'(in_ready), 32'd0);
            if (a) idx++;
            cyc++;
        end
        check("stream_accepted", 32'(idx), 32'd6);
        drain();
        check("cnt_after_6", 32'(cnt), 32'd6);

        // two items in flight, then reset, then the functional sequence again
        for (int i = 0; i < 2; i++) cycle(1'b0, 2'd0, 1'b1, rnd_data(), 1'b1, a);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b1, d030[i], 1'b1, a);
        drain();
        check("cnt_resume_3", 32'(cnt), 32'd3);

        // stress from reset: output every cycle once the pipe is full
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 2'd1, 1'b0, rnd_data(), 1'b1, a);
            if (i >= 2) check("stress_valid", 32'(out_valid), 32'd1);
        end
        // hold, then stress again to confirm the LFSR stayed frozen
        for (int i = 0; i < 10; i++) cycle(1'b0, 2'd2, 1'b0, rnd_data(), 1'b1, a);
        for (int i = 0; i < 10; i++) cycle(1'b0, 2'd1, 1'b0, rnd_data(), 1'b1, a);
        drain();

        // random mix of modes, data, valid and backpressure
        for (int i = 0; i < 400; i++) begin
            md   = 2'($urandom_range(0, 3));
            ordy = (md == 2'd1 || md == 2'd2) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(1'b0, md, 1'($urandom_range(0, 1)), rnd_data(), ordy, a);
        end
        drain();

        // long stress run to saturate the counter
        do_reset();
        for (int i = 0; i < 65545; i++) cycle(1'b0, 2'd1, 1'b0, '0, 1'b1, a);
        check("cnt_saturated", 32'(cnt), 32'h0000FFFF);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd1, 1'b0, '0, 1'b1, a);
        drain();
        check("cnt_stays_saturated", 32'(cnt), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
